// File: rtl/fifo_word_unpacker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_word_unpacker_pkg
// Description : Shared defaults, FSM state encoding and helper function for
//               the FIFO word unpacker (read side of the async FIFO).
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_word_unpacker_pkg;

  // Default geometry: 32-bit FIFO words unpacked into 8-bit beats
  localparam int DEF_WIDTH = 32;
  localparam int DEF_LANE  = 8;
  localparam int DEF_CNT_W = 16;

  // Read-side FSM: wait for data, pulse remove, capture data_out, stream beats
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_CAPT = 2'd2,
    ST_SEND = 2'd3
  } state_t;

  // Index width for a counter over n items; never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_word_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : fifo_word_unpacker
// Description : Pops WIDTH-bit words from the async FIFO read port (clk_out
//               domain) and streams them as LANE-bit valid/ready beats, least
//               significant lane first. Counts completed words.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_word_unpacker
  import fifo_word_unpacker_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,   // must be an integer multiple of LANE
  parameter int LANE  = DEF_LANE,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_out,
  input  logic             reset,       // asynchronous, active-low
  input  logic             flush,       // synchronous clear, shared with FIFO
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_remove,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [LANE-1:0]  m_data,
  output logic             m_last,
  output logic [CNT_W-1:0] words_done
);

  localparam int LANES  = WIDTH / LANE;
  localparam int LIDX_W = idx_width(LANES);

  localparam logic [LIDX_W-1:0] C_LAST_LANE = LIDX_W'(LANES - 1);

  state_t              r_state;
  logic [WIDTH-1:0]    r_word;
  logic [LIDX_W-1:0]   r_lane;
  logic                r_remove;
  logic                r_valid;
  logic [LANE-1:0]     r_data;
  logic                r_last;
  logic [CNT_W-1:0]    r_words_done;

  logic [LIDX_W-1:0]   w_next_lane;
  logic [LANE-1:0]     w_lanes [LANES];

  // Lane view of the captured word, lane 0 in the least significant bits
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign w_lanes[gi] = r_word[gi*LANE +: LANE];
  end

  // Lane that follows the one currently presented; only used before the last lane
  assign w_next_lane = r_lane + 1'b1;

  // Read FSM with registered FIFO remove and registered stream outputs
  always_ff @(posedge clk_out or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_word       <= '0;
      r_lane       <= '0;
      r_remove     <= 1'b0;
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_last       <= 1'b0;
      r_words_done <= '0;
    end else if (flush) begin
      // Flush discards any word being fetched or partially sent
      r_state      <= ST_IDLE;
      r_lane       <= '0;
      r_remove     <= 1'b0;
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_last       <= 1'b0;
      r_words_done <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            r_remove <= 1'b1;
            r_state  <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Remove is high for exactly this cycle; data_out is valid next cycle
          r_remove <= 1'b0;
          r_state  <= ST_CAPT;
        end
        ST_CAPT: begin
          r_word  <= fifo_data;
          r_valid <= 1'b1;
          r_data  <= fifo_data[LANE-1:0];
          r_last  <= (LANES == 1);
          r_lane  <= '0;
          r_state <= ST_SEND;
        end
        ST_SEND: begin
          if (r_valid && m_ready) begin
            if (r_lane != C_LAST_LANE) begin
              r_lane <= w_next_lane;
              r_data <= w_lanes[w_next_lane];
              r_last <= (w_next_lane == C_LAST_LANE);
            end else begin
              // Word complete; chain straight into the next pop if data waits
              r_words_done <= r_words_done + 1'b1;
              r_valid      <= 1'b0;
              r_last       <= 1'b0;
              r_lane       <= '0;
              if (!fifo_empty) begin
                r_remove <= 1'b1;
                r_state  <= ST_REQ;
              end else begin
                r_state  <= ST_IDLE;
              end
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign fifo_remove = r_remove;
  assign m_valid     = r_valid;
  assign m_data      = r_data;
  assign m_last      = r_last;
  assign words_done  = r_words_done;

endmodule
`default_nettype wire

// File: tb/tb_fifo_word_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_word_unpacker
// Description : Directed self-checking bench for fifo_word_unpacker with a
//               behavioural FIFO read-port model and a beat collector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_word_unpacker;

  logic        clk_out = 1'b0;
  logic        reset   = 1'b0;
  logic        flush   = 1'b0;
  logic        fifo_empty;
  logic [31:0] fifo_data = '0;
  logic        fifo_remove;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [7:0]  m_data;
  logic        m_last;
  logic [15:0] words_done;

  int checks = 0;
  int errors = 0;

  // FIFO model storage: written by the stimulus, read by the model process
  logic [31:0] mem [1024];
  int wr_cnt = 0;
  int rd_idx = 0;

  // Remove monitor counters
  int remove_cnt  = 0;
  int rem_empty   = 0;
  int rem_double  = 0;
  logic prev_remove = 1'b0;

  // Beat collector
  logic [7:0] beat_data [1024];
  logic       beat_last [1024];
  int         beat_cyc  [1024];
  int nb  = 0;
  int cyc = 0;

  fifo_word_unpacker #(
    .WIDTH (32),
    .LANE  (8),
    .CNT_W (16)
  ) dut (
    .clk_out     (clk_out),
    .reset       (reset),
    .flush       (flush),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_remove (fifo_remove),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .words_done  (words_done)
  );

  always #5 clk_out = ~clk_out;

  assign fifo_empty = (rd_idx == wr_cnt);

  // FIFO read port: data_out updates the cycle after remove is sampled
  always @(posedge clk_out) begin
    if (flush) begin
      rd_idx <= wr_cnt;
    end else if (fifo_remove && (rd_idx != wr_cnt)) begin
      fifo_data <= mem[rd_idx];
      rd_idx    <= rd_idx + 1;
    end
    if (fifo_remove) begin
      remove_cnt <= remove_cnt + 1;
      if (fifo_empty)  rem_empty  <= rem_empty + 1;
      if (prev_remove) rem_double <= rem_double + 1;
    end
    prev_remove <= fifo_remove;
  end

  // Record every accepted beat with the cycle it was accepted in
  always @(posedge clk_out) begin
    cyc <= cyc + 1;
    if (reset && m_valid && m_ready) begin
      beat_data[nb] <= m_data;
      beat_last[nb] <= m_last;
      beat_cyc[nb]  <= cyc;
      nb <= nb + 1;
    end
  end

  task automatic push_word(input logic [31:0] w);
    mem[wr_cnt] = w;
    wr_cnt = wr_cnt + 1;
  endtask

  task automatic wait_beats(input int target, input int budget, input string name);
    int n = 0;
    while (nb < target && n < budget) begin
      @(negedge clk_out);
      n++;
    end
    checks++;
    if (nb < target) begin
      errors++;
      $display("FAIL %s timeout: beats %0d required %0d", name, nb, target);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_out);
    checks++;
    if ({fifo_remove, m_valid, m_last} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl remove/valid/last=%b required 000", {fifo_remove, m_valid, m_last});
    end
    checks++;
    if (m_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data m_data=%h required 00", m_data);
    end
    checks++;
    if (words_done !== 16'h0000) begin
      errors++;
      $display("FAIL reset_words words_done=%h required 0000", words_done);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk_out);
  endtask

  task automatic test_single();
    logic [7:0] exp [4];
    int b0, r0;
    exp[0] = 8'hEF; exp[1] = 8'hBE; exp[2] = 8'hAD; exp[3] = 8'hDE;
    m_ready = 1'b1;
    @(negedge clk_out);
    b0 = nb;
    r0 = remove_cnt;
    push_word(32'hDEADBEEF);
    @(posedge clk_out); #1;
    checks++;
    if (fifo_remove !== 1'b1) begin
      errors++;
      $display("FAIL single_remove_c1 fifo_remove=%b required 1", fifo_remove);
    end
    @(posedge clk_out); #1;
    checks++;
    if ({fifo_remove, m_valid} !== 2'b00) begin
      errors++;
      $display("FAIL single_c2 remove/valid=%b required 00", {fifo_remove, m_valid});
    end
    @(posedge clk_out); #1;
    checks++;
    if ({m_valid, m_data, m_last} !== {1'b1, 8'hEF, 1'b0}) begin
      errors++;
      $display("FAIL single_c3 valid/data/last=%b/%h/%b required 1/ef/0", m_valid, m_data, m_last);
    end
    wait_beats(b0 + 4, 20, "single");
    repeat (3) @(negedge clk_out);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({beat_data[b0+i], beat_last[b0+i]} !== {exp[i], (i == 3)}) begin
        errors++;
        $display("FAIL single_beat%0d data/last=%h/%b required %h/%b",
                 i, beat_data[b0+i], beat_last[b0+i], exp[i], (i == 3));
      end
    end
    checks++;
    if (words_done !== 16'd1) begin
      errors++;
      $display("FAIL single_words words_done=%0d required 1", words_done);
    end
    checks++;
    if (remove_cnt - r0 !== 1) begin
      errors++;
      $display("FAIL single_remove_count removes=%0d required 1", remove_cnt - r0);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [4];
    int b0, n;
    exp[0] = 8'h44; exp[1] = 8'h33; exp[2] = 8'h22; exp[3] = 8'h11;
    m_ready = 1'b0;
    b0 = nb;
    push_word(32'h11223344);
    n = 0;
    while (!m_valid && n < 10) begin
      @(negedge clk_out);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({m_valid, m_data, m_last} !== {1'b1, 8'h44, 1'b0}) begin
        errors++;
        $display("FAIL hold_cycle%0d valid/data/last=%b/%h/%b required 1/44/0", i, m_valid, m_data, m_last);
      end
      @(negedge clk_out);
    end
    m_ready = 1'b1;
    wait_beats(b0 + 4, 20, "backpressure");
    repeat (2) @(negedge clk_out);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({beat_data[b0+i], beat_last[b0+i]} !== {exp[i], (i == 3)}) begin
        errors++;
        $display("FAIL bp_beat%0d data/last=%h/%b required %h/%b",
                 i, beat_data[b0+i], beat_last[b0+i], exp[i], (i == 3));
      end
    end
    checks++;
    if (words_done !== 16'd2) begin
      errors++;
      $display("FAIL bp_words words_done=%0d required 2", words_done);
    end
  endtask

  task automatic test_back_to_back();
    int b0, w0, r0, idx;
    logic [31:0] w;
    m_ready = 1'b1;
    @(negedge clk_out);
    b0 = nb;
    w0 = wr_cnt;
    r0 = remove_cnt;
    for (int i = 0; i < 128; i++) push_word($urandom);
    wait_beats(b0 + 512, 128 * 6 + 40, "back_to_back");
    repeat (3) @(negedge clk_out);
    for (int i = 0; i < 128; i++) begin
      w = mem[w0 + i];
      for (int l = 0; l < 4; l++) begin
        idx = b0 + 4 * i + l;
        checks++;
        if ({beat_data[idx], beat_last[idx]} !== {w[l*8 +: 8], (l == 3)}) begin
          errors++;
          $display("FAIL b2b_w%0d_l%0d data/last=%h/%b required %h/%b",
                   i, l, beat_data[idx], beat_last[idx], w[l*8 +: 8], (l == 3));
        end
        checks++;
        if (beat_cyc[idx] - beat_cyc[b0] !== 6 * i + l) begin
          errors++;
          $display("FAIL b2b_timing_w%0d_l%0d offset=%0d required %0d",
                   i, l, beat_cyc[idx] - beat_cyc[b0], 6 * i + l);
        end
      end
    end
    checks++;
    if (rem_empty !== 0 || rem_double !== 0) begin
      errors++;
      $display("FAIL remove_rules while_empty=%0d double=%0d required 0/0", rem_empty, rem_double);
    end
    checks++;
    if (remove_cnt - r0 !== 128) begin
      errors++;
      $display("FAIL b2b_removes removes=%0d required 128", remove_cnt - r0);
    end
    checks++;
    if (words_done !== 16'd130) begin
      errors++;
      $display("FAIL b2b_words words_done=%0d required 130", words_done);
    end
  endtask

  task automatic test_flush();
    int b0, n, seen;
    m_ready = 1'b1;
    @(negedge clk_out);
    b0 = nb;
    push_word(32'hCAFEF00D);
    n = 0;
    while (nb < b0 + 2 && n < 20) begin
      @(negedge clk_out);
      n++;
    end
    m_ready = 1'b0;
    flush   = 1'b1;
    @(posedge clk_out); #1;
    checks++;
    if ({m_valid, m_last, fifo_remove} !== 3'b000) begin
      errors++;
      $display("FAIL flush_ctrl valid/last/remove=%b required 000", {m_valid, m_last, fifo_remove});
    end
    checks++;
    if (words_done !== 16'd0) begin
      errors++;
      $display("FAIL flush_words words_done=%0d required 0", words_done);
    end
    @(negedge clk_out);
    flush   = 1'b0;
    m_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk_out);
      if (m_valid) seen++;
    end
    checks++;
    if (seen !== 0 || nb !== b0 + 2) begin
      errors++;
      $display("FAIL flush_quiet valid_cycles=%0d beats=%0d required 0/%0d", seen, nb - b0, 2);
    end
    checks++;
    if ({beat_data[b0], beat_data[b0+1]} !== 16'h0DF0) begin
      errors++;
      $display("FAIL flush_partial beats=%h%h required 0df0", beat_data[b0], beat_data[b0+1]);
    end
  endtask

  task automatic test_reset_mid();
    int b0, r0, seen;
    m_ready = 1'b1;
    @(negedge clk_out);
    b0 = nb;
    push_word(32'h55AA55AA);
    @(posedge clk_out);
    @(posedge clk_out); #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({fifo_remove, m_valid, m_last, m_data} !== 11'd0) begin
      errors++;
      $display("FAIL reset_mid_clear remove/valid/last/data=%b/%b/%b/%h required 0/0/0/00",
               fifo_remove, m_valid, m_last, m_data);
    end
    repeat (2) @(negedge clk_out);
    reset = 1'b1;
    r0 = remove_cnt;
    seen = 0;
    repeat (10) begin
      @(negedge clk_out);
      if (m_valid) seen++;
    end
    checks++;
    if (seen !== 0 || nb !== b0 || remove_cnt !== r0) begin
      errors++;
      $display("FAIL reset_mid_quiet valid_cycles=%0d beats=%0d removes=%0d required 0/0/0",
               seen, nb - b0, remove_cnt - r0);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp [4];
    int b0;
    exp[0] = 8'h04; exp[1] = 8'h03; exp[2] = 8'h02; exp[3] = 8'h01;
    m_ready = 1'b1;
    @(negedge clk_out);
    force dut.r_words_done = 16'hFFFF;
    @(negedge clk_out);
    release dut.r_words_done;
    b0 = nb;
    push_word(32'h01020304);
    wait_beats(b0 + 4, 20, "wrap");
    repeat (2) @(negedge clk_out);
    checks++;
    if (words_done !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_words words_done=%h required 0000", words_done);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({beat_data[b0+i], beat_last[b0+i]} !== {exp[i], (i == 3)}) begin
        errors++;
        $display("FAIL wrap_beat%0d data/last=%h/%b required %h/%b",
                 i, beat_data[b0+i], beat_last[b0+i], exp[i], (i == 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always terminates
  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
